// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the GTP_PLL_E1 dynamic-reconfiguration controller.
package pll_ctrl_pkg;

    localparam int DEFAULT_RATIO_W = 10;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_RUN,
        ST_GATE,
        ST_FAIL
    } pll_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_LOCK    = 2'd2;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the raw PLL LOCK into the controller clock domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // NOTE: flops use non-blocking assignments so meta and sync_out sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/pll_dyn_reconfig_ctrl.sv
// Validates divider/duty requests, applies them to the PLL dynamic ports and
// sequences reset, lock qualification, retry and automatic relock.
module pll_dyn_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int                           NUM_OUT       = 5,
    parameter int                           RATIO_W       = DEFAULT_RATIO_W,
    parameter logic [RATIO_W-1:0]           INIT_RATIOI   = RATIO_W'(2),
    parameter logic [RATIO_W-1:0]           INIT_RATIOF   = RATIO_W'(24),
    parameter logic [NUM_OUT*RATIO_W-1:0]   INIT_RATIO    = {NUM_OUT{RATIO_W'(16)}},
    parameter logic [NUM_OUT*RATIO_W-1:0]   INIT_DUTY     = {NUM_OUT{RATIO_W'(16)}},
    parameter int                           RST_CYCLES    = 16,
    parameter int                           LOCK_TIMEOUT  = 65535,
    parameter int                           STABLE_CYCLES = 256,
    parameter int                           LOSS_CYCLES   = 4,
    parameter int                           MAX_RETRY     = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [RATIO_W-1:0]           req_ratioi,
    input  logic [RATIO_W-1:0]           req_ratiof,
    input  logic [NUM_OUT*RATIO_W-1:0]   req_ratio,
    input  logic [NUM_OUT*RATIO_W-1:0]   req_duty,
    input  logic                         pll_lock,
    output logic                         pll_rst,
    output logic [RATIO_W-1:0]           dyn_ratioi,
    output logic [RATIO_W-1:0]           dyn_ratiof,
    output logic [NUM_OUT*RATIO_W-1:0]   dyn_ratio,
    output logic [NUM_OUT*RATIO_W-1:0]   dyn_duty,
    output logic [NUM_OUT-1:0]           out_en,
    output logic                         locked,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic [7:0]                   loss_cnt
);

    localparam int CNT_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RUN_MAX = (STABLE_CYCLES > LOSS_CYCLES) ? STABLE_CYCLES : LOSS_CYCLES;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   GATE_LAST    = CNT_W'(1);
    localparam logic [RUN_W-1:0]   STABLE_LAST  = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [RUN_W-1:0]   LOSS_LAST    = RUN_W'(LOSS_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
    localparam logic [RATIO_W:0]   DUTY_ONE     = (RATIO_W+1)'(1);

    pll_state_e state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               from_req_q, from_req_d;
    logic [1:0]         err_code_d;
    logic [7:0]         loss_cnt_d;
    logic               done_d, err_d, capture, load_dyn, lock_s, accept, req_legal;

    logic [RATIO_W-1:0]         hold_ratioi, hold_ratiof;
    logic [NUM_OUT*RATIO_W-1:0] hold_ratio, hold_duty;
    logic [RATIO_W-1:0]         ratio_c;
    logic [RATIO_W:0]           duty_c, duty_max;

    pll_lock_sync u_lock_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pll_lock),
        .sync_out (lock_s)
    );

    assign accept = req_valid && req_ready;

    // Duty is in half-VCO periods, so the legal range per channel is 1 .. 2*ratio-1.
    always_comb begin
        req_legal = (req_ratioi != '0) && (req_ratiof != '0);
        ratio_c   = '0;
        duty_c    = '0;
        duty_max  = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            ratio_c  = req_ratio[i*RATIO_W +: RATIO_W];
            duty_c   = {1'b0, req_duty[i*RATIO_W +: RATIO_W]};
            duty_max = {ratio_c, 1'b0} - DUTY_ONE;
            if (ratio_c == '0 || duty_c == '0 || duty_c > duty_max) begin
                req_legal = 1'b0;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        retry_d    = retry_q;
        from_req_d = from_req_q;
        err_code_d = err_code;
        loss_cnt_d = loss_cnt;
        done_d     = 1'b0;
        err_d      = 1'b0;
        capture    = 1'b0;
        load_dyn   = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    run_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                run_d = lock_s ? run_q + RUN_W'(1) : '0;
                if (lock_s && run_q == STABLE_LAST) begin
                    state_d    = ST_RUN;
                    done_d     = from_req_q;
                    from_req_d = 1'b0;
                    cnt_d      = '0;
                    run_d      = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    run_d = '0;
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_RESET;
                    end else begin
                        state_d    = ST_FAIL;
                        err_d      = 1'b1;
                        err_code_d = ERR_LOCK;
                        from_req_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN, ST_FAIL: begin
                // A request takes priority over a coincident lock-loss detection.
                if (accept) begin
                    if (req_legal) begin
                        capture    = 1'b1;
                        state_d    = ST_GATE;
                        cnt_d      = '0;
                        run_d      = '0;
                        retry_d    = '0;
                        err_code_d = ERR_NONE;
                        from_req_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                    end
                end else if (state_q == ST_RUN) begin
                    run_d = lock_s ? '0 : run_q + RUN_W'(1);
                    if (!lock_s && run_q == LOSS_LAST) begin
                        state_d = ST_RESET;
                        cnt_d   = '0;
                        run_d   = '0;
                        retry_d = '0;
                        if (loss_cnt != 8'hff) loss_cnt_d = loss_cnt + 8'd1;
                    end
                end
            end
            ST_GATE: begin
                if (cnt_q == GATE_LAST) begin
                    cnt_d    = '0;
                    load_dyn = 1'b1;
                    state_d  = ST_RESET;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            run_q      <= '0;
            retry_q    <= '0;
            from_req_q <= 1'b0;
            pll_rst    <= 1'b1;
            out_en     <= '0;
            req_ready  <= 1'b0;
            locked     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            loss_cnt   <= '0;
            dyn_ratioi <= INIT_RATIOI;
            dyn_ratiof <= INIT_RATIOF;
            dyn_ratio  <= INIT_RATIO;
            dyn_duty   <= INIT_DUTY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            retry_q    <= retry_d;
            from_req_q <= from_req_d;
            pll_rst    <= (state_d == ST_RESET);
            out_en     <= (state_d == ST_RUN) ? '1 : '0;
            req_ready  <= (state_d == ST_RUN) || (state_d == ST_FAIL);
            locked     <= (state_d == ST_RUN);
            done       <= done_d;
            err        <= err_d;
            err_code   <= err_code_d;
            loss_cnt   <= loss_cnt_d;
            if (load_dyn) begin
                dyn_ratioi <= hold_ratioi;
                dyn_ratiof <= hold_ratiof;
                dyn_ratio  <= hold_ratio;
                dyn_duty   <= hold_duty;
            end
        end
    end

    // NOTE: the holding register is pure data qualified by the FSM, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            hold_ratioi <= req_ratioi;
            hold_ratiof <= req_ratiof;
            hold_ratio  <= req_ratio;
            hold_duty   <= req_duty;
        end
    end

endmodule
